// File: rtl/bsg_link_sched_pkg.sv
// bsg_link_sched_pkg: shared FSM state type and default parameters for the upstream link scheduler.
package bsg_link_sched_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
    localparam int WIDTH_DEF         = 64;
    localparam int NUM_IN_DEF        = 2;
    localparam int CREDIT_MAX_DEF    = 16;
    localparam int LG_CREDIT_DEC_DEF = 3;
endpackage

// File: rtl/bsg_link_rr_arb.sv
// bsg_link_rr_arb: round-robin arbiter; priority starts just after the last granted requester.
module bsg_link_rr_arb #(
    parameter int num_in_p = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [num_in_p-1:0] reqs_i,
    input  logic                grant_en_i,
    output logic [num_in_p-1:0] grants_o
);
    localparam int lg_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

    logic [lg_lp-1:0] ptr_q, ptr_d, idx;
    logic [lg_lp:0]   sum;
    logic             found;

    always_comb begin
        grants_o = '0;
        ptr_d    = ptr_q;
        found    = 1'b0;
        idx      = '0;
        sum      = '0;
        for (int k = 0; k < num_in_p; k++) begin
            sum = {1'b0, ptr_q} + (lg_lp+1)'(k);
            idx = (sum >= (lg_lp+1)'(num_in_p)) ? lg_lp'(sum - (lg_lp+1)'(num_in_p)) : lg_lp'(sum);
            if (!found && reqs_i[idx]) begin
                found         = 1'b1;
                grants_o[idx] = grant_en_i;
                ptr_d         = (idx == lg_lp'(num_in_p-1)) ? '0 : idx + 1'b1;
            end
        end
        if (!grant_en_i) ptr_d = ptr_q;
    end

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) ptr_q <= '0;
        else         ptr_q <= ptr_d;
endmodule

// File: rtl/bsg_link_upstream_sched.sv
// bsg_link_upstream_sched: credit-based round-robin scheduler feeding a one-flit output register.
module bsg_link_upstream_sched
    import bsg_link_sched_pkg::*;
#(
    parameter int width_p                = WIDTH_DEF,
    parameter int num_in_p               = NUM_IN_DEF,
    parameter int credit_max_p           = CREDIT_MAX_DEF,
    parameter int lg_credit_decimation_p = LG_CREDIT_DEC_DEF
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                link_enable_i,
    input  logic [num_in_p-1:0]                 valid_i,
    input  logic [num_in_p*width_p-1:0]         data_i,
    output logic [num_in_p-1:0]                 yumi_o,
    output logic                                link_valid_o,
    output logic [width_p-1:0]                  link_data_o,
    input  logic                                link_ready_i,
    input  logic                                token_i,
    output logic [$clog2(credit_max_p+1)-1:0]   credits_o,
    output logic                                idle_o,
    output logic                                overflow_o
);
    localparam int                cw_lp         = $clog2(credit_max_p+1);
    localparam logic [cw_lp-1:0]  credit_max_lp = cw_lp'(credit_max_p);

    state_e              state_q, state_d;
    logic [cw_lp-1:0]    credits_q, credits_d;
    logic                overflow_q, overflow_d, valid_q, valid_d;
    logic [width_p-1:0]  data_q, data_d, grant_data;
    logic [num_in_p-1:0] grants;
    logic [31:0]         sum;
    logic                grant_en, dequeue;

    assign dequeue  = valid_q & link_ready_i;
    // the output slot may be refilled in the same cycle it drains
    assign grant_en = (state_q == RUN) && (credits_q != '0) && (|valid_i) && (!valid_q || dequeue);

    bsg_link_rr_arb #(.num_in_p(num_in_p)) arb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .reqs_i    (valid_i),
        .grant_en_i(grant_en),
        .grants_o  (grants)
    );

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < num_in_p; i++)
            if (grants[i]) grant_data = grant_data | data_i[i*width_p +: width_p];
    end

    always_comb begin
        sum        = 32'(credits_q) + (token_i ? (32'd1 << lg_credit_decimation_p) : 32'd0) - (grant_en ? 32'd1 : 32'd0);
        credits_d  = (sum > 32'(credit_max_p)) ? credit_max_lp : cw_lp'(sum);
        overflow_d = overflow_q | (sum > 32'(credit_max_p));
        valid_d    = grant_en ? 1'b1 : (dequeue ? 1'b0 : valid_q);
        data_d     = grant_en ? grant_data : data_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (link_enable_i) state_d = RUN;
            RUN:     if (!link_enable_i) state_d = DRAIN;
            DRAIN:   if (link_enable_i) state_d = RUN;
                     else if (!valid_q && credits_q == credit_max_lp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state_q    <= IDLE;
            credits_q  <= credit_max_lp;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end

    assign yumi_o       = grants;
    assign link_valid_o = valid_q;
    assign link_data_o  = data_q;
    assign credits_o    = credits_q;
    assign idle_o       = (state_q == IDLE);
    assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_bsg_link_upstream_sched.sv
// tb_bsg_link_upstream_sched: table-driven vectors plus directed credit/drain/reset sequences.
module tb_bsg_link_upstream_sched;
    logic         clk = 1'b0, reset_i = 1'b1, en = 1'b0, ready = 1'b0, token = 1'b0;
    logic [1:0]   valid = 2'b00, yumi, ys;
    logic [63:0]  d0 = 64'hA0A0_0000_0000_0001, d1 = 64'hB0B0_0000_0000_0002, held;
    logic [127:0] data;
    logic         link_valid, idle, ovf;
    logic [63:0]  link_data;
    logic [4:0]   credits;
    int           n_cmp = 0, n_bad = 0, cnt;

    typedef struct {
        logic en; logic [1:0] v; logic r; logic [1:0] y; logic [4:0] c; logic lv; logic [63:0] d;
    } vec_t;
    vec_t tbl[13];

    assign data = {d1, d0};

    bsg_link_upstream_sched dut (
        .clk_i(clk), .reset_i(reset_i), .link_enable_i(en), .valid_i(valid), .data_i(data),
        .yumi_o(yumi), .link_valid_o(link_valid), .link_data_o(link_data), .link_ready_i(ready),
        .token_i(token), .credits_o(credits), .idle_o(idle), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        #1 ys = yumi;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_i = 1'b1; en = 1'b0; valid = 2'b00; ready = 1'b0; token = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'b11, 1'b1, 2'b00, 5'd16, 1'b0, 64'h0};
        tbl[1]  = '{1'b1, 2'b11, 1'b1, 2'b01, 5'd15, 1'b1, d0};
        tbl[2]  = '{1'b1, 2'b11, 1'b1, 2'b10, 5'd14, 1'b1, d1};
        tbl[3]  = '{1'b1, 2'b11, 1'b1, 2'b01, 5'd13, 1'b1, d0};
        tbl[4]  = '{1'b1, 2'b01, 1'b1, 2'b01, 5'd12, 1'b1, d0};
        tbl[5]  = '{1'b1, 2'b00, 1'b1, 2'b00, 5'd12, 1'b0, d0};
        tbl[6]  = '{1'b1, 2'b11, 1'b0, 2'b10, 5'd11, 1'b1, d1};
        tbl[7]  = '{1'b1, 2'b11, 1'b0, 2'b00, 5'd11, 1'b1, d1};
        tbl[8]  = '{1'b1, 2'b11, 1'b1, 2'b01, 5'd10, 1'b1, d0};
        tbl[9]  = '{1'b0, 2'b11, 1'b1, 2'b10, 5'd9,  1'b1, d1};
        tbl[10] = '{1'b0, 2'b11, 1'b1, 2'b00, 5'd9,  1'b0, d1};
        tbl[11] = '{1'b1, 2'b11, 1'b1, 2'b00, 5'd9,  1'b0, d1};
        tbl[12] = '{1'b1, 2'b11, 1'b1, 2'b01, 5'd8,  1'b1, d0};

        do_reset();
        chk("reset_credits", credits, 16);
        chk("reset_valid", link_valid, 0);
        chk("reset_data", link_data, 0);
        chk("reset_idle", idle, 1);
        chk("reset_ovf", ovf, 0);
        for (int i = 0; i < 13; i++) begin
            en = tbl[i].en; valid = tbl[i].v; ready = tbl[i].r;
            cyc();
            chk($sformatf("vec%0d_yumi", i), ys, tbl[i].y);
            chk($sformatf("vec%0d_credits", i), credits, tbl[i].c);
            chk($sformatf("vec%0d_valid", i), link_valid, tbl[i].lv);
            chk($sformatf("vec%0d_data", i), link_data, tbl[i].d);
        end

        // credit exhaustion then a single token
        do_reset();
        en = 1'b1; valid = 2'b01; ready = 1'b1; cnt = 0;
        for (int i = 0; i < 40; i++) begin cyc(); cnt += (ys != 2'b00) ? 1 : 0; end
        chk("exhaust_grants", cnt, 16);
        chk("exhaust_credits", credits, 0);
        chk("exhaust_valid", link_valid, 0);
        token = 1'b1; cyc(); token = 1'b0;
        chk("token_credits", credits, 8);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin cyc(); cnt += (ys != 2'b00) ? 1 : 0; end
        chk("token_grants", cnt, 8);
        chk("token_exhaust", credits, 0);

        // backpressure holds the flit, then refill on the dequeue cycle
        do_reset();
        en = 1'b1; valid = 2'b01; ready = 1'b1;
        cyc(); cyc();
        held = d0;
        ready = 1'b0; valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            d0 = d0 + 64'd16;
            cyc();
            chk($sformatf("bp%0d_yumi", i), ys, 2'b00);
            chk($sformatf("bp%0d_data", i), link_data, held);
            chk($sformatf("bp%0d_valid", i), link_valid, 1);
        end
        ready = 1'b1; cyc();
        chk("bp_release_yumi", ys, 2'b10);
        chk("bp_release_data", link_data, d1);
        d0 = 64'hA0A0_0000_0000_0001;

        // simultaneous grant and token at credits 3
        do_reset();
        en = 1'b1; valid = 2'b01; ready = 1'b1;
        for (int i = 0; i < 14; i++) cyc();
        chk("net_pre_credits", credits, 3);
        token = 1'b1; cyc(); token = 1'b0;
        chk("net_yumi", ys, 2'b01);
        chk("net_credits", credits, 10);
        chk("net_ovf", ovf, 0);

        // overflow at credits 12
        do_reset();
        en = 1'b1; valid = 2'b01; ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("ovf_pre_credits", credits, 12);
        valid = 2'b00; token = 1'b1; cyc(); token = 1'b0;
        chk("ovf_credits", credits, 16);
        chk("ovf_set", ovf, 1);
        for (int i = 0; i < 3; i++) cyc();
        chk("ovf_sticky", ovf, 1);

        // drain to idle
        do_reset();
        en = 1'b1; valid = 2'b01; ready = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        chk("drain_pre_credits", credits, 10);
        en = 1'b0; valid = 2'b00; cyc();
        chk("drain_not_idle", idle, 0);
        valid = 2'b01; cyc();
        chk("drain_no_grant", ys, 2'b00);
        chk("drain_credits", credits, 10);
        token = 1'b1; cyc(); token = 1'b0;
        chk("drain_sat_credits", credits, 16);
        cyc();
        chk("drain_idle", idle, 1);
        cyc();
        chk("idle_no_grant", ys, 2'b00);

        // reset mid-flit, with a token during reset
        do_reset();
        en = 1'b1; valid = 2'b01; ready = 1'b0;
        cyc(); cyc();
        chk("midflit_valid", link_valid, 1);
        #2 reset_i = 1'b1; token = 1'b1;
        #1;
        chk("rst_valid", link_valid, 0);
        chk("rst_credits", credits, 16);
        chk("rst_yumi", yumi, 2'b00);
        chk("rst_data", link_data, 0);
        @(negedge clk); token = 1'b0;
        @(negedge clk); reset_i = 1'b0; en = 1'b0;
        chk("rst_token_ignored", credits, 16);
        chk("rst_token_ovf", ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bsg_link_upstream_sched.md
BSG_LINK_UPSTREAM_SCHED -- requirements
Module: bsg_link_upstream_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- width_p, 64, flit width.
- num_in_p, 2, number of requesters.
- credit_max_p, 16, link credits available after reset.
- lg_credit_decimation_p, 3, log2 of credits returned per token pulse.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, single clock.
- reset_i, in, 1, asynchronous active-high reset.
- link_enable_i, in, 1, level; permits new grants.
- valid_i, in, num_in_p, per-requester valid.
- data_i, in, num_in_p*width_p, requester i at slice [i*width_p +: width_p].
- yumi_o, out, num_in_p, one-hot accept, same cycle as grant.
- link_valid_o, out, 1, output flit valid.
- link_data_o, out, width_p, output flit.
- link_ready_i, in, 1, downstream (upstream-link core side) ready.
- token_i, in, 1, synchronized single-cycle credit-return pulse.
- credits_o, out, $clog2(credit_max_p+1), current credit count.
- idle_o, out, 1, state==IDLE.
- overflow_o, out, 1, sticky credit-overflow error.

REQ-003 Clock and reset SHALL be exactly one clock, clk_i, and reset_i, which is asynchronous and active-high.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-005 From IDLE the FSM SHALL go to RUN on link_enable_i=1.
REQ-006 From RUN the FSM SHALL go to DRAIN on link_enable_i=0.
REQ-007 From DRAIN the FSM SHALL go to IDLE when the output register is empty and credits_o==credit_max_p; it SHALL go back to RUN if link_enable_i=1 before that.
REQ-008 A grant SHALL occur only when all of these hold:
- state is RUN;
- credits_o>0;
- at least one valid_i bit is 1;
- the output register is empty, or is being emptied this cycle (link_valid_o & link_ready_i).
REQ-009 Arbitration SHALL be round-robin: the highest-priority requester is the one after the last granted, and reset priority is requester 0.
REQ-010 On a grant, yumi_o SHALL assert for exactly that requester, and the data SHALL load into the output register; link_valid_o SHALL be 1 on the next cycle (latency 1).
REQ-011 link_valid_o and link_data_o SHALL hold stable until link_valid_o & link_ready_i.
REQ-012 Back-to-back grants SHALL sustain 1 flit/cycle when link_ready_i=1 and credits are available.
REQ-013 credits_o SHALL decrement by 1 on each grant and increment by 2^lg_credit_decimation_p on each token_i pulse.
REQ-014 When a grant and a token_i pulse occur in the same cycle, credits_o SHALL apply the net change in that cycle.
REQ-015 If an increment would exceed credit_max_p, credits_o SHALL saturate at credit_max_p and overflow_o SHALL set and stay set until reset.
REQ-016 No grant SHALL be issued at credits_o==0, so the credit count never underflows.
REQ-017 In IDLE and DRAIN, yumi_o SHALL be 0; a flit already in the output register SHALL still complete.
REQ-018 yumi_o SHALL never assert for a requester whose valid_i is 0.

Reset
REQ-019 Asserting reset_i SHALL immediately set:
- state to IDLE;
- link_valid_o to 0;
- link_data_o to 0;
- yumi_o to 0;
- credits_o to credit_max_p;
- overflow_o to 0;
- the round-robin pointer to requester 0.
REQ-020 Reset mid-transfer SHALL discard the held flit without a handshake; no credit is restored for the discarded flit beyond the reset value.
REQ-021 token_i pulses arriving during reset SHALL be ignored.

Structure
REQ-022 Package bsg_link_sched_pkg SHALL hold the FSM state enum (IDLE, RUN, DRAIN) and the default parameter constants.
REQ-023 Round-robin arbitration SHALL be a sub-module, bsg_link_rr_arb, with inputs reqs_i and grant_en_i and outputs a one-hot grants_o; its pointer SHALL update only when grant_en_i=1 and a request exists.
REQ-024 The credit counter, output register and FSM SHALL be in the top module; all storage SHALL be flops on clk_i with reset_i in the sensitivity list.

Verification
REQ-025 Credit exhaustion:
- stimulus: enable, valid_i=2'b01 held, link_ready_i=1, no tokens;
- response: exactly 16 yumi_o pulses, then credits_o=0 and link_valid_o falls after the 16th flit;
- then one token_i: credits_o=8 and 8 further grants.
REQ-026 Round-robin fairness:
- stimulus: valid_i=2'b11 held, ample credits;
- response: grants alternate 0,1,0,1 and link_data_o alternates between the requesters' data.
REQ-027 Backpressure:
- stimulus: link_ready_i=0 for 5 cycles with a flit held;
- response: link_data_o stable, yumi_o=0 until ready returns, then a grant on the same cycle as the dequeue.
REQ-028 Simultaneous grant and token at credits_o=3: credits_o=10 next cycle.
REQ-029 Overflow: token_i at credits_o=12 -> credits_o=16 and overflow_o=1.
REQ-030 Drain and reset:
- link_enable_i falls with credits_o=10 -> DRAIN with no grants; one token_i -> credits_o=16 (saturated) and IDLE, so idle_o=1;
- separately, reset_i mid-flit -> link_valid_o=0 and credits_o=16 immediately.
